// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state and default bus widths.
package cpu_types_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/memory_response_ctrl.sv
// Arbitrates instruction and data requests onto the single RAM port and
// returns one-cycle ihit/dhit pulses with registered load data.
module memory_response_ctrl
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} resp_state_t;

  localparam logic [7:0]        TMO        = 8'(TIMEOUT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  resp_state_t       state;
  logic [7:0]        waitCnt;
  ramstate_t         rs;
  logic              dreq;
  logic              dread;
  logic              giveUp;
  logic [ADDR_W-1:0] dalign;
  logic [ADDR_W-1:0] ialign;

  assign rs     = ramstate_t'(ramstate);
  assign dreq   = dREN | dWEN;
  assign dread  = dREN & ~dWEN;
  assign giveUp = (rs == ERROR) || (waitCnt == TMO);
  assign dalign = daddr & ALIGN_MASK;
  assign ialign = iaddr & ALIGN_MASK;

  // Completion outranks abort: a finished access is always reported even if the request drops.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      waitCnt  <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      mem_err  <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (dreq) begin
            state    <= DACC;
            ramaddr  <= dalign;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= dread;
          end else if (iREN) begin
            state   <= IACC;
            ramaddr <= ialign;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
          end else begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end
        end
        DACC: begin
          if (rs != ACCESS && waitCnt != TMO) waitCnt <= waitCnt + 8'd1;
          if (rs == ACCESS) begin
            if (dread) dload <= ramload;
            dhit   <= 1'b1;
            state  <= DONE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end else if (giveUp) begin
            mem_err <= 1'b1;
            dhit    <= 1'b1;
            state   <= DONE;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
          end else if (!dreq) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end else begin
            ramaddr  <= dalign;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= dread;
          end
        end
        IACC: begin
          if (rs != ACCESS && waitCnt != TMO) waitCnt <= waitCnt + 8'd1;
          if (rs == ACCESS) begin
            iload  <= ramload;
            ihit   <= 1'b1;
            state  <= DONE;
            ramREN <= 1'b0;
          end else if (giveUp) begin
            mem_err <= 1'b1;
            ihit    <= 1'b1;
            state   <= DONE;
            ramREN  <= 1'b0;
          end else if (!iREN) begin
            state  <= IDLE;
            ramREN <= 1'b0;
          end else begin
            ramaddr <= ialign;
            ramREN  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_response_ctrl.sv
// Randomized self-checking bench: a transaction-level timing model predicts every output cycle by cycle.
module tb_memory_response_ctrl;
  import cpu_types_pkg::*;

  localparam int TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  memory_response_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lastIhitCyc = -1;
  int lastDhitCyc = -1;
  bit checkEn = 1'b0;

  logic        expIhit = 0, expDhit = 0, expRen = 0, expWen = 0, expErr = 0;
  logic [31:0] expIload = 0, expDload = 0, expAddr = 0, expStore = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h want %h", name, cyc, act, want);
    end
  endtask

  // Every cycle the model is live, all outputs are held against its prediction.
  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("ihit", {31'b0, ihit}, {31'b0, expIhit});
      checkOutput("dhit", {31'b0, dhit}, {31'b0, expDhit});
      checkOutput("ramREN", {31'b0, ramREN}, {31'b0, expRen});
      checkOutput("ramWEN", {31'b0, ramWEN}, {31'b0, expWen});
      checkOutput("mem_err", {31'b0, mem_err}, {31'b0, expErr});
      checkOutput("iload", iload, expIload);
      checkOutput("dload", dload, expDload);
      if (expRen || expWen) checkOutput("ramaddr", ramaddr, expAddr);
      if (expWen) checkOutput("ramstore", ramstore, expStore);
    end
    if (ihit) lastIhitCyc = cyc;
    if (dhit) lastDhitCyc = cyc;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic setIdleExp();
    expIhit = 0;
    expDhit = 0;
    expRen  = 0;
    expWen  = 0;
  endtask

  // One access starting now with the controller idle: nBusy non-ACCESS cycles then ACCESS/ERROR,
  // or a timeout once TIMEOUT waiting cycles have been counted. Returns the hit offset.
  task automatic applyStimulus(input bit isData, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] loadVal, input int nBusy,
                               input bit endErr, output int hitAt);
    int  k;
    bit  timedOut;
    bit  okRead;
    if (isData) begin
      dREN = rd; dWEN = wr; daddr = addr; dstore = wdata;
    end else begin
      iREN = 1'b1; iaddr = addr;
    end
    ramstate = FREE;
    setIdleExp();
    timedOut = (nBusy >= TIMEOUT);
    k = timedOut ? TIMEOUT + 1 : nBusy + 1;
    for (int c = 1; c <= k; c++) begin
      tick();
      ramload = $urandom;
      if (c == k && !timedOut) begin
        ramstate = endErr ? ERROR : ACCESS;
        ramload  = loadVal;
      end else begin
        ramstate = BUSY;
      end
      expIhit  = 0;
      expDhit  = 0;
      expRen   = !isData || (rd && !wr);
      expWen   = isData && wr;
      expAddr  = addr & 32'hFFFF_FFFC;
      expStore = wdata;
    end
    tick();
    ramstate = FREE;
    okRead = !timedOut && !endErr;
    if (isData) begin
      dREN = 0; dWEN = 0;
      expDhit = 1;
      if (okRead && rd && !wr) expDload = loadVal;
    end else begin
      iREN = 0;
      expIhit = 1;
      if (okRead) expIload = loadVal;
    end
    if (!okRead) expErr = 1;
    expRen = 0;
    expWen = 0;
    hitAt = k + 1;
    tick();
    setIdleExp();
  endtask

  initial begin
    int hitAt, hitAt2, s, kind;
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;

    repeat (3) @(posedge CLK);
    #2;
    checkOutput("resetRamREN", {31'b0, ramREN}, 32'd0);
    checkOutput("resetRamaddr", ramaddr, 32'd0);
    checkOutput("resetIload", iload, 32'd0);
    checkOutput("resetErr", {31'b0, mem_err}, 32'd0);
    @(negedge CLK) nRST = 1;
    tick();
    checkEn = 1;
    tick();

    // Instruction fetch, two BUSY cycles before ACCESS.
    s = cyc;
    applyStimulus(0, 0, 0, 32'h40, 0, 32'h2402000A, 2, 0, hitAt);
    checkOutput("fetchLatencyModel", hitAt, 32'd4);
    checkOutput("fetchLatencyDut", lastIhitCyc - s, 32'd4);
    checkOutput("fetchWord", iload, 32'h2402000A);

    // Simultaneous fetch and store: data is served first.
    iREN = 1; iaddr = 32'h44;
    applyStimulus(1, 0, 1, 32'h80, 32'hDEAD, 0, 1, 0, hitAt);
    applyStimulus(0, 0, 0, 32'h44, 0, 32'h1111_2222, 0, 0, hitAt2);
    checkOutput("dataFirst", {31'b0, lastDhitCyc < lastIhitCyc}, 32'd1);
    checkOutput("minLatency", hitAt2, 32'd2);

    // Fetch withdrawn after one BUSY cycle.
    iREN = 1; iaddr = 32'h100; setIdleExp();
    tick(); ramstate = BUSY; expRen = 1; expAddr = 32'h100;
    tick(); iREN = 0;
    tick(); ramstate = FREE; setIdleExp();
    checkOutput("abortRamREN", {31'b0, ramREN}, 32'd0);
    tick();
    tick();

    // Randomized traffic, occasionally paired with a pending fetch and a rare RAM ERROR.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        applyStimulus(0, 0, 0, $urandom, 0, $urandom, $urandom_range(0, 4),
                      ($urandom_range(0, 15) == 0), hitAt);
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          iREN = 1; iaddr = $urandom;
          applyStimulus(1, kind != 2, kind != 1, $urandom, $urandom, $urandom,
                        $urandom_range(0, 4), ($urandom_range(0, 15) == 0), hitAt);
          applyStimulus(0, 0, 0, iaddr, 0, $urandom, $urandom_range(0, 4), 0, hitAt);
        end else begin
          applyStimulus(1, kind != 2, kind != 1, $urandom, $urandom, $urandom,
                        $urandom_range(0, 4), ($urandom_range(0, 15) == 0), hitAt);
        end
      end
    end

    // RAM ERROR on a read keeps the previous load word.
    applyStimulus(1, 1, 0, 32'h200, 0, 32'h1234_5678, 1, 0, hitAt);
    checkOutput("loadBeforeErr", dload, 32'h1234_5678);
    applyStimulus(1, 1, 0, 32'h204, 0, 32'hBAD0_BAD0, 0, 1, hitAt);
    checkOutput("loadKeptOnErr", dload, 32'h1234_5678);
    checkOutput("errSticky", {31'b0, mem_err}, 32'd1);

    // RAM never answers: timeout.
    s = cyc;
    applyStimulus(1, 1, 0, 32'h300, 0, 0, 40, 0, hitAt);
    checkOutput("timeoutModel", hitAt, 32'd17);
    checkOutput("timeoutDut", lastDhitCyc - s, 32'd17);
    checkOutput("errAfterTimeout", {31'b0, mem_err}, 32'd1);

    // Asynchronous reset in the middle of a store.
    dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_0001; setIdleExp();
    tick(); ramstate = BUSY; expWen = 1; expAddr = 32'h80; expStore = 32'hDEAD_0001;
    tick();
    #2;
    checkEn = 0;
    nRST = 0;
    #1;
    checkOutput("rstRamWEN", {31'b0, ramWEN}, 32'd0);
    checkOutput("rstRamstore", ramstore, 32'd0);
    checkOutput("rstErr", {31'b0, mem_err}, 32'd0);
    checkOutput("rstDload", dload, 32'd0);
    dWEN = 0; ramstate = FREE;
    tick();
    @(negedge CLK) nRST = 1;
    setIdleExp(); expErr = 0; expIload = 0; expDload = 0;
    tick();
    checkEn = 1;
    tick();

    for (int n = 0; n < 10; n++) begin
      applyStimulus(n[0], 1, 0, $urandom, 0, $urandom, $urandom_range(0, 3), 0, hitAt);
    end

    checkEn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
